// File: rtl/decode_exec_unit.sv
// RV32I decode/execute stage: registers the fetched instruction and PC, then
// decodes fields, immediate and control strobes and evaluates the ALU and branch.
module decode_exec_unit #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DWIDTH-1:0] insn_i,
   input  logic [AWIDTH-1:0] pc_i,
   input  logic [DWIDTH-1:0] rs1data_i,
   input  logic [DWIDTH-1:0] rs2data_i,
   output logic [AWIDTH-1:0] pc_o,
   output logic [DWIDTH-1:0] insn_o,
   output logic [6:0]        opcode_o,
   output logic [4:0]        rd_o,
   output logic [4:0]        rs1_o,
   output logic [4:0]        rs2_o,
   output logic [2:0]        funct3_o,
   output logic [6:0]        funct7_o,
   output logic [4:0]        shamt_o,
   output logic [31:0]       imm_o,
   output logic              pcsel_o,
   output logic              immsel_o,
   output logic              regwren_o,
   output logic              rs1sel_o,
   output logic              rs2sel_o,
   output logic              memren_o,
   output logic              memwren_o,
   output logic [1:0]        wbsel_o,
   output logic [3:0]        alusel_o,
   output logic [DWIDTH-1:0] alu_res_o,
   output logic              br_taken_o
);

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_SYSTEM = 7'h73;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_PASS = 4'd10;

   logic [DWIDTH-1:0] insn;
   logic [AWIDTH-1:0] pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         insn <= DWIDTH'(32'h0000_0013);
         pc   <= '0;
      end else begin
         insn <= insn_i;
         pc   <= pc_i;
      end
   end

   assign pc_o     = pc;
   assign insn_o   = insn;
   assign opcode_o = insn[6:0];
   assign rd_o     = insn[11:7];
   assign funct3_o = insn[14:12];
   assign rs1_o    = insn[19:15];
   assign rs2_o    = insn[24:20];
   assign funct7_o = insn[31:25];
   assign shamt_o  = insn[24:20];

   always_comb begin
      imm_o = '0;
      case (insn[6:0])
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
            imm_o = {{20{insn[31]}}, insn[31:20]};
         OP_STORE:  imm_o = {{20{insn[31]}}, insn[31:25], insn[11:7]};
         OP_BRANCH: imm_o = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
         OP_LUI, OP_AUIPC: imm_o = {insn[31:12], 12'b0};
         OP_JAL:    imm_o = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
         default:   imm_o = '0;
      endcase
   end

   // shared funct3 -> ALU op map; SUB only exists for register-register ops
   logic [3:0] func_op;
   always_comb begin
      func_op = ALU_ADD;
      case (insn[14:12])
         3'b000: func_op = (insn[30] && insn[6:0] == OP_R) ? ALU_SUB : ALU_ADD;
         3'b001: func_op = ALU_SLL;
         3'b010: func_op = ALU_SLT;
         3'b011: func_op = ALU_SLTU;
         3'b100: func_op = ALU_XOR;
         3'b101: func_op = insn[30] ? ALU_SRA : ALU_SRL;
         3'b110: func_op = ALU_OR;
         default: func_op = ALU_AND;
      endcase
   end

   logic known;
   logic jalr;
   always_comb begin
      pcsel_o   = 1'b0;
      immsel_o  = 1'b0;
      regwren_o = 1'b0;
      rs1sel_o  = 1'b0;
      rs2sel_o  = 1'b0;
      memren_o  = 1'b0;
      memwren_o = 1'b0;
      wbsel_o   = 2'b00;
      alusel_o  = ALU_ADD;
      known     = 1'b1;
      jalr      = 1'b0;
      case (insn[6:0])
         OP_R: begin
            regwren_o = 1'b1;
            alusel_o  = func_op;
         end
         OP_IMM: begin
            regwren_o = 1'b1; immsel_o = 1'b1; rs2sel_o = 1'b1;
            alusel_o  = func_op;
         end
         OP_LOAD: begin
            regwren_o = 1'b1; immsel_o = 1'b1; rs2sel_o = 1'b1;
            memren_o  = 1'b1; wbsel_o = 2'b01;
         end
         OP_STORE: begin
            immsel_o = 1'b1; rs2sel_o = 1'b1; memwren_o = 1'b1;
         end
         OP_BRANCH: begin
            pcsel_o = 1'b1; immsel_o = 1'b1; rs1sel_o = 1'b1; rs2sel_o = 1'b1;
         end
         OP_JAL: begin
            pcsel_o = 1'b1; immsel_o = 1'b1; rs1sel_o = 1'b1; rs2sel_o = 1'b1;
            regwren_o = 1'b1; wbsel_o = 2'b10;
         end
         OP_JALR: begin
            pcsel_o = 1'b1; immsel_o = 1'b1; rs2sel_o = 1'b1;
            regwren_o = 1'b1; wbsel_o = 2'b10; jalr = 1'b1;
         end
         OP_LUI: begin
            regwren_o = 1'b1; immsel_o = 1'b1; rs2sel_o = 1'b1;
            alusel_o  = ALU_PASS;
         end
         OP_AUIPC: begin
            regwren_o = 1'b1; immsel_o = 1'b1; rs2sel_o = 1'b1; rs1sel_o = 1'b1;
         end
         default: known = 1'b0;
      endcase
   end

   logic [DWIDTH-1:0] opa, opb, alu_out;
   assign opa = rs1sel_o ? DWIDTH'(pc) : rs1data_i;
   assign opb = rs2sel_o ? DWIDTH'($signed(imm_o)) : rs2data_i;

   always_comb begin
      alu_out = '0;
      case (alusel_o)
         ALU_ADD:  alu_out = opa + opb;
         ALU_SUB:  alu_out = opa - opb;
         ALU_SLL:  alu_out = opa << opb[4:0];
         ALU_SLT:  alu_out = DWIDTH'($signed(opa) < $signed(opb));
         ALU_SLTU: alu_out = DWIDTH'(opa < opb);
         ALU_XOR:  alu_out = opa ^ opb;
         ALU_SRL:  alu_out = opa >> opb[4:0];
         ALU_SRA:  alu_out = $signed(opa) >>> opb[4:0];
         ALU_OR:   alu_out = opa | opb;
         ALU_AND:  alu_out = opa & opb;
         ALU_PASS: alu_out = opb;
         default:  alu_out = '0;
      endcase
   end

   always_comb begin
      alu_res_o = '0;
      if (known) alu_res_o = jalr ? (alu_out & ~DWIDTH'(1)) : alu_out;
   end

   always_comb begin
      br_taken_o = 1'b0;
      if (insn[6:0] == OP_BRANCH) begin
         case (insn[14:12])
            3'b000:  br_taken_o = (rs1data_i == rs2data_i);
            3'b001:  br_taken_o = (rs1data_i != rs2data_i);
            3'b100:  br_taken_o = ($signed(rs1data_i) < $signed(rs2data_i));
            3'b101:  br_taken_o = ($signed(rs1data_i) >= $signed(rs2data_i));
            3'b110:  br_taken_o = (rs1data_i < rs2data_i);
            3'b111:  br_taken_o = (rs1data_i >= rs2data_i);
            default: br_taken_o = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_decode_exec_unit.sv
// Scoreboard bench for decode_exec_unit: a driver issues directed instructions and
// queues hand-computed results; a monitor checks them one cycle later.
module tb_decode_exec_unit;

   typedef struct {
      logic [31:0] insn, pc, rs1, rs2;
      logic        rst;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic [31:0] res;
      logic        br;
      logic [6:0]  strb;   // {pcsel,immsel,regwren,rs1sel,rs2sel,memren,memwren}
      logic [1:0]  wb;
      logic [31:0] pco;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [31:0] insn_i = 32'h0000_0013, pc_i = '0, rs1data_i = '0, rs2data_i = '0;
   logic [31:0] pc_o, insn_o, imm_o, alu_res_o;
   logic [6:0]  opcode_o, funct7_o;
   logic [4:0]  rd_o, rs1_o, rs2_o, shamt_o;
   logic [2:0]  funct3_o;
   logic        pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o;
   logic [1:0]  wbsel_o;
   logic [3:0]  alusel_o;
   logic        br_taken_o;

   decode_exec_unit #(.AWIDTH(32), .DWIDTH(32)) dut (
      .clk(clk), .reset(reset), .insn_i(insn_i), .pc_i(pc_i),
      .rs1data_i(rs1data_i), .rs2data_i(rs2data_i),
      .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o), .rd_o(rd_o),
      .rs1_o(rs1_o), .rs2_o(rs2_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
      .shamt_o(shamt_o), .imm_o(imm_o), .pcsel_o(pcsel_o), .immsel_o(immsel_o),
      .regwren_o(regwren_o), .rs1sel_o(rs1sel_o), .rs2sel_o(rs2sel_o),
      .memren_o(memren_o), .memwren_o(memwren_o), .wbsel_o(wbsel_o),
      .alusel_o(alusel_o), .alu_res_o(alu_res_o), .br_taken_o(br_taken_o)
   );

   always #5 clk = ~clk;

   vec_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   logic issue = 1'b0;
   logic pend = 1'b0;
   logic done = 1'b0;

   always @(posedge clk) pend <= issue;

   function automatic vec_t mk(input logic [31:0] insn, pc, rs1, rs2, input logic rst,
                               input logic [6:0] op, input logic [4:0] rd,
                               input logic [31:0] imm, input logic [3:0] alu,
                               input logic [31:0] res, input logic br,
                               input logic [6:0] strb, input logic [1:0] wb,
                               input logic [31:0] pco);
      vec_t v;
      v.insn = insn; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.rst = rst;
      v.op = op; v.rd = rd; v.imm = imm; v.alu = alu; v.res = res; v.br = br;
      v.strb = strb; v.wb = wb; v.pco = pco;
      return v;
   endfunction

   task automatic cmp(input string name, input int idx, input logic [31:0] act, exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL vec%0d %s: got 0x%08h, expected 0x%08h", idx, name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      reset     = v.rst;
      insn_i    = v.insn;
      pc_i      = v.pc;
      rs1data_i = v.rs1;
      rs2data_i = v.rs2;
      issue     = 1'b1;
      sb.push_back(v);
   endtask

   // monitor
   initial begin
      vec_t e;
      forever begin
         @(posedge clk);
         #2;
         if (pend) begin
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL scoreboard_empty: got output with no queued expectation");
            end else begin
               e = sb.pop_front();
               vectors++;
               cmp("opcode",  vectors, 32'(opcode_o),  32'(e.op));
               cmp("rd",      vectors, 32'(rd_o),      32'(e.rd));
               cmp("imm",     vectors, imm_o,          e.imm);
               cmp("alusel",  vectors, 32'(alusel_o),  32'(e.alu));
               cmp("alu_res", vectors, alu_res_o,      e.res);
               cmp("br_taken",vectors, 32'(br_taken_o),32'(e.br));
               cmp("strobes", vectors,
                   32'({pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o}),
                   32'(e.strb));
               cmp("wbsel",   vectors, 32'(wbsel_o),   32'(e.wb));
               cmp("pc_o",    vectors, pc_o,           e.pco);
            end
         end
      end
   end

   // driver
   initial begin
      // reset loads addi x0,x0,0 and PC 0
      apply(mk(32'h0050_0093, 32'h100, 32'h1234_5678, 32'h0, 1'b1,
               7'h13, 5'd0, 32'h0, 4'd0, 32'h1234_5678, 1'b0, 7'b0110100, 2'b00, 32'h0));
      apply(mk(32'h0050_0093, 32'h1000, 32'h0, 32'h0, 1'b0,
               7'h13, 5'd1, 32'h5, 4'd0, 32'h5, 1'b0, 7'b0110100, 2'b00, 32'h1000));
      apply(mk(32'h4020_8133, 32'h1004, 32'h7, 32'h9, 1'b0,
               7'h33, 5'd2, 32'h0, 4'd1, 32'hFFFF_FFFE, 1'b0, 7'b0010000, 2'b00, 32'h1004));
      apply(mk(32'h0020_8463, 32'h0100_0010, 32'h3, 32'h3, 1'b0,
               7'h63, 5'd8, 32'h8, 4'd0, 32'h0100_0018, 1'b1, 7'b1101100, 2'b00, 32'h0100_0010));
      apply(mk(32'h0020_8463, 32'h0100_0010, 32'h3, 32'h4, 1'b0,
               7'h63, 5'd8, 32'h8, 4'd0, 32'h0100_0018, 1'b0, 7'b1101100, 2'b00, 32'h0100_0010));
      apply(mk(32'h0000_8067, 32'h2000, 32'h0100_0021, 32'h0, 1'b0,
               7'h67, 5'd0, 32'h0, 4'd0, 32'h0100_0020, 1'b0, 7'b1110100, 2'b10, 32'h2000));
      apply(mk(32'hFFC1_2083, 32'h2004, 32'h0200_0010, 32'h0, 1'b0,
               7'h03, 5'd1, 32'hFFFF_FFFC, 4'd0, 32'h0200_000C, 1'b0, 7'b0110110, 2'b01, 32'h2004));
      // srai: funct7[5] set, shamt 4, arithmetic fill
      apply(mk(32'h4040_D193, 32'h2008, 32'h8000_0010, 32'h0, 1'b0,
               7'h13, 5'd3, 32'h0000_0404, 4'd7, 32'hF800_0001, 1'b0, 7'b0110100, 2'b00, 32'h2008));
      // sltiu against sign-extended -1 (all ones unsigned)
      apply(mk(32'hFFF0_B213, 32'h200C, 32'h5, 32'h0, 1'b0,
               7'h13, 5'd4, 32'hFFFF_FFFF, 4'd4, 32'h1, 1'b0, 7'b0110100, 2'b00, 32'h200C));
      apply(mk(32'h0020_A2B3, 32'h2010, 32'hFFFF_FFFF, 32'h1, 1'b0,
               7'h33, 5'd5, 32'h0, 4'd3, 32'h1, 1'b0, 7'b0010000, 2'b00, 32'h2010));
      // bgeu with backward offset, operand has MSB set
      apply(mk(32'hFE20_FEE3, 32'h100, 32'h8000_0000, 32'h1, 1'b0,
               7'h63, 5'd29, 32'hFFFF_FFFC, 4'd0, 32'h0000_00FC, 1'b1, 7'b1101100, 2'b00, 32'h100));
      apply(mk(32'hABCD_E337, 32'h104, 32'h5555_5555, 32'h0, 1'b0,
               7'h37, 5'd6, 32'hABCD_E000, 4'd10, 32'hABCD_E000, 1'b0, 7'b0110100, 2'b00, 32'h104));
      apply(mk(32'h0100_00EF, 32'h400, 32'h7777, 32'h0, 1'b0,
               7'h6F, 5'd1, 32'h10, 4'd0, 32'h410, 1'b0, 7'b1111100, 2'b10, 32'h400));
      apply(mk(32'h0020_A423, 32'h404, 32'h100, 32'hDEAD, 1'b0,
               7'h23, 5'd8, 32'h8, 4'd0, 32'h108, 1'b0, 7'b0100101, 2'b00, 32'h404));
      apply(mk(32'h0000_1397, 32'h3000, 32'h9999, 32'h0, 1'b0,
               7'h17, 5'd7, 32'h1000, 4'd0, 32'h4000, 1'b0, 7'b0111100, 2'b00, 32'h3000));
      apply(mk(32'h0000_0073, 32'h3004, 32'h5, 32'h5, 1'b0,
               7'h73, 5'd0, 32'h0, 4'd0, 32'h0, 1'b0, 7'b0000000, 2'b00, 32'h3004));
      // reset mid-stream overrides the incoming ecall
      apply(mk(32'h0000_0073, 32'h3008, 32'hA5, 32'h0, 1'b1,
               7'h13, 5'd0, 32'h0, 4'd0, 32'hA5, 1'b0, 7'b0110100, 2'b00, 32'h0));
      @(negedge clk);
      issue = 1'b0;
      reset = 1'b0;
      repeat (4) @(negedge clk);
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      done = 1'b1;
      $finish;
   end

   initial begin
      #5000;
      if (!done) begin
         $display("FAIL timeout: bench did not complete within 5000 time units");
         $fatal(1, "timeout");
      end
   end

endmodule
